// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART memory-mapped controller.
// Register offsets, CON bit positions and the TX state encoding.
// No logic; imported by the interface users and the top module.
package uart_mmio_pkg;

  localparam logic [31:0] OFS_TXD = 32'h0000_0018;
  localparam logic [31:0] OFS_RXD = 32'h0000_001C;
  localparam logic [31:0] OFS_CON = 32'h0000_0020;

  localparam int CON_TX_IE    = 0;
  localparam int CON_RX_IE    = 1;
  localparam int CON_TX_DONE  = 2;
  localparam int CON_RX_VALID = 3;
  localparam int CON_TX_BUSY  = 4;
  localparam int CON_RX_OVR   = 5;
  localparam int CON_TX_DROP  = 6;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_BUSY = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_mmio_if.sv
// CPU data-bus view of the UART controller (single-cycle MIPS load/store).
// Latency: writes take effect at the strobe edge; read data is combinational.
// Backpressure: none, every strobe is accepted in its own cycle.
interface uart_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_write;
  logic        mem_read;

  modport master (output addr, wdata, mem_write, mem_read, input rdata);
  modport slave  (input addr, wdata, mem_write, mem_read, output rdata);
endinterface

// File: rtl/uart_mmio_ctrl_sync_edge.sv
// Multi-flop synchronizer for a slow asynchronous status line, with rise detect.
// Latency: level appears STAGES cycles after the input changes; rise is a one-cycle pulse.
// Backpressure: none.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the chain and remember the last synced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped TXD/RXD/CON registers, event flags, TX handshake FSM and level irq.
// Latency: register writes act at the strobe edge, irq follows flags by one cycle.
// Backpressure: a TXD write while a send is in flight is dropped and flagged in tx_drop.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          SYNC_STAGES = 2,
  parameter int          REQ_TIMEOUT = 1023
) (
  input  logic         sysclk,
  input  logic         reset,
  uart_mmio_if.slave   bus,
  input  logic [7:0]   uart_rx_data,
  input  logic         uart_rx_status,
  input  logic         uart_tx_status,
  output logic [7:0]   uart_tx_data,
  output logic         uart_tx_ctrl,
  output logic         irq
);

  localparam int          CNT_W  = $clog2(REQ_TIMEOUT + 1);
  localparam logic [29:0] W_TXD  = 30'((BASE_ADDR + OFS_TXD) >> 2);
  localparam logic [29:0] W_RXD  = 30'((BASE_ADDR + OFS_RXD) >> 2);
  localparam logic [29:0] W_CON  = 30'((BASE_ADDR + OFS_CON) >> 2);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       tx_data_q;
  logic             tx_ctrl_q;

  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_drop_q, tx_drop_d;
  logic       tx_ie_q, tx_ie_d;
  logic       rx_ie_q, rx_ie_d;
  logic       irq_q, irq_d;

  logic rx_rise, rx_lvl, tx_lvl, tx_rise_unused;
  logic hit_txd, hit_rxd, hit_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic tx_busy, tx_done_set, tx_drop_set, req_timeout;
  logic [31:0] con_vec;
  logic unused_bits;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rx_sync (
    .clk(sysclk), .reset(reset), .d_i(uart_rx_status), .level_o(rx_lvl), .rise_o(rx_rise)
  );

  // Sender idles high, so its synchronizer resets to 1 to avoid a fake busy phase.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_tx_sync (
    .clk(sysclk), .reset(reset), .d_i(uart_tx_status), .level_o(tx_lvl), .rise_o(tx_rise_unused)
  );

  assign hit_txd = (bus.addr[31:2] == W_TXD);
  assign hit_rxd = (bus.addr[31:2] == W_RXD);
  assign hit_con = (bus.addr[31:2] == W_CON);
  assign wr_txd  = bus.mem_write & hit_txd;
  assign wr_con  = bus.mem_write & hit_con;
  assign rd_rxd  = bus.mem_read & hit_rxd;
  assign rd_con  = bus.mem_read & hit_con;

  assign tx_busy     = (state_q != TX_IDLE);
  assign req_timeout = (state_q == TX_REQ) & tx_lvl & (cnt_q == CNT_W'(REQ_TIMEOUT));
  assign tx_done_set = (state_q == TX_BUSY) & tx_lvl;
  assign tx_drop_set = (wr_txd & tx_busy) | req_timeout;

  assign con_vec = {25'b0, tx_drop_q, rx_ovr_q, tx_busy, rx_valid_q, tx_done_q, rx_ie_q, tx_ie_q};

  // Read mux: only a strobed hit drives data; TXD and unmapped offsets read as 0.
  always_comb begin
    bus.rdata = 32'b0;
    if (rd_rxd) bus.rdata = {24'b0, rx_buf_q};
    else if (rd_con) bus.rdata = con_vec;
  end

  // Flag next-state: clears first, then set events so a coincident set wins.
  always_comb begin
    rx_buf_d   = rx_buf_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    tx_done_d  = tx_done_q;
    tx_drop_d  = tx_drop_q;
    tx_ie_d    = tx_ie_q;
    rx_ie_d    = rx_ie_q;
    if (rd_rxd) rx_valid_d = 1'b0;
    if (rd_con) tx_done_d = 1'b0;
    if (wr_con) begin
      tx_ie_d = bus.wdata[CON_TX_IE];
      rx_ie_d = bus.wdata[CON_RX_IE];
      if (bus.wdata[CON_RX_OVR])  rx_ovr_d  = 1'b0;
      if (bus.wdata[CON_TX_DROP]) tx_drop_d = 1'b0;
    end
    if (rx_rise) begin
      rx_buf_d   = uart_rx_data;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_rxd) rx_ovr_d = 1'b1;
    end
    if (tx_done_set) tx_done_d = 1'b1;
    if (tx_drop_set) tx_drop_d = 1'b1;
    irq_d = (tx_ie_q & tx_done_q) | (rx_ie_q & rx_valid_q);
  end

  // Flag and interrupt registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_buf_q   <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_drop_q  <= 1'b0;
      tx_ie_q    <= 1'b0;
      rx_ie_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rx_buf_q   <= rx_buf_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_done_q  <= tx_done_d;
      tx_drop_q  <= tx_drop_d;
      tx_ie_q    <= tx_ie_d;
      rx_ie_q    <= rx_ie_d;
      irq_q      <= irq_d;
    end
  end

  // TX handshake: raise the request, wait for the sender to go busy, then idle again.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      tx_ctrl_q <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (wr_txd) begin
            tx_data_q <= bus.wdata[7:0];
            cnt_q     <= '0;
            tx_ctrl_q <= 1'b1;
            state_q   <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (!tx_lvl) begin
            tx_ctrl_q <= 1'b0;
            state_q   <= TX_BUSY;
          end else if (cnt_q == CNT_W'(REQ_TIMEOUT)) begin
            tx_ctrl_q <= 1'b0;
            state_q   <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        TX_BUSY: begin
          if (tx_lvl) state_q <= TX_IDLE;
        end
        default: begin
          tx_ctrl_q <= 1'b0;
          state_q   <= TX_IDLE;
        end
      endcase
    end
  end

  assign uart_tx_data = tx_data_q;
  assign uart_tx_ctrl = tx_ctrl_q;
  assign irq          = irq_q;
  assign unused_bits  = ^{bus.addr[1:0], bus.wdata[31:8], rx_lvl, tx_rise_unused};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl with a flag-level reference model.
// Latency: inputs driven on the falling edge, outputs sampled away from the rising edge.
// Backpressure: not applicable.
module tb_uart_mmio_ctrl;

  localparam int          SYNC = 2;
  localparam int          TMO  = 1023;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic       sysclk, reset;
  logic [7:0] rx_data, tx_data;
  logic       rx_status, tx_status, tx_ctrl, irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register-level view of the flags
  logic [7:0] m_rx_buf;
  logic m_rx_valid, m_rx_ovr, m_tx_done, m_tx_drop, m_tx_ie, m_rx_ie;

  uart_mmio_if bus ();

  uart_mmio_ctrl #(.BASE_ADDR(32'h4000_0000), .SYNC_STAGES(SYNC), .REQ_TIMEOUT(TMO)) dut (
    .sysclk(sysclk), .reset(reset), .bus(bus),
    .uart_rx_data(rx_data), .uart_rx_status(rx_status), .uart_tx_status(tx_status),
    .uart_tx_data(tx_data), .uart_tx_ctrl(tx_ctrl), .irq(irq)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic logic [31:0] con_exp(input logic busy);
    return {25'b0, m_tx_drop, m_rx_ovr, busy, m_rx_valid, m_tx_done, m_rx_ie, m_tx_ie};
  endfunction

  function automatic logic irq_exp();
    return (m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_valid);
  endfunction

  task automatic model_clear();
    m_rx_buf = 8'h00; m_rx_valid = 0; m_rx_ovr = 0;
    m_tx_done = 0; m_tx_drop = 0; m_tx_ie = 0; m_rx_ie = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge sysclk);
    bus.addr = a; bus.wdata = d; bus.mem_write = 1'b1;
    @(negedge sysclk);
    bus.mem_write = 1'b0;
    if (a == A_CON) begin
      m_tx_ie = d[0];
      m_rx_ie = d[1];
      if (d[5]) m_rx_ovr = 0;
      if (d[6]) m_tx_drop = 0;
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge sysclk);
    bus.addr = a; bus.mem_read = 1'b1;
    #1 d = bus.rdata;
    @(negedge sysclk);
    bus.mem_read = 1'b0;
    if (a == A_RXD) m_rx_valid = 0;
    if (a == A_CON) m_tx_done = 0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge sysclk);
    rx_data = b; rx_status = 1'b1;
    repeat (SYNC + 3) @(negedge sysclk);
    rx_status = 1'b0;
    repeat (SYNC + 2) @(negedge sysclk);
    if (m_rx_valid) m_rx_ovr = 1;
    m_rx_buf = b;
    m_rx_valid = 1;
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset = 1'b1;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    model_clear();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
    n_checks++; if (tx_ctrl !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0", tx_ctrl); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_txdata got %h exp 00", tx_data); end
    bus.addr = A_CON;
    #1;
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_nostrobe got %h exp 0", bus.rdata); end
    bus_read(A_CON, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_con got %h exp 0", d); end
  endtask

  task automatic test_rx_irq();
    logic [31:0] d, e;
    logic seen;
    bus_write(A_CON, 32'h3);
    @(negedge sysclk);
    rx_data = 8'h5A; rx_status = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < SYNC + 2; i++) begin
      @(negedge sysclk);
      if (irq) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rx_irq_latency got %b exp 1", seen); end
    repeat (2) @(negedge sysclk);
    rx_status = 1'b0;
    repeat (SYNC + 2) @(negedge sysclk);
    m_rx_buf = 8'h5A; m_rx_valid = 1;
    e = con_exp(1'b0);
    bus_read(A_CON, d);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL rx_con got %h exp %h", d, e); end
    bus_read(A_RXD, d);
    n_checks++; if (d !== 32'h5A) begin n_fail++; $display("FAIL rx_data got %h exp 5a", d); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rx_irq_hold got %b exp 1", irq); end
    @(negedge sysclk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_drop got %b exp 0", irq); end
  endtask

  task automatic test_tx();
    logic [31:0] d, e;
    bus_write(A_TXD, 32'hA5);
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL tx_data got %h exp a5", tx_data); end
    n_checks++; if (tx_ctrl !== 1'b1) begin n_fail++; $display("FAIL tx_ctrl_req got %b exp 1", tx_ctrl); end
    repeat (3) @(negedge sysclk);
    tx_status = 1'b0;
    repeat (SYNC + 2) @(negedge sysclk);
    n_checks++; if (tx_ctrl !== 1'b0) begin n_fail++; $display("FAIL tx_ctrl_busy got %b exp 0", tx_ctrl); end
    e = con_exp(1'b1);
    bus_read(A_CON, d);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL tx_con_busy got %h exp %h", d, e); end
    repeat (100) @(negedge sysclk);
    tx_status = 1'b1;
    repeat (SYNC + 4) @(negedge sysclk);
    m_tx_done = 1;
    n_checks++; if (irq !== irq_exp()) begin n_fail++; $display("FAIL tx_irq got %b exp %b", irq, irq_exp()); end
    e = con_exp(1'b0);
    bus_read(A_CON, d);
    n_checks++; if (d !== e || d[2] !== 1'b1) begin n_fail++; $display("FAIL tx_done_set got %h exp %h", d, e); end
    e = con_exp(1'b0);
    bus_read(A_CON, d);
    n_checks++; if (d !== e || d[2] !== 1'b0) begin n_fail++; $display("FAIL tx_done_clr got %h exp %h", d, e); end
  endtask

  task automatic test_tx_drop();
    logic [31:0] d, e;
    bus_write(A_TXD, 32'hA5);
    repeat (3) @(negedge sysclk);
    tx_status = 1'b0;
    repeat (SYNC + 2) @(negedge sysclk);
    bus_write(A_TXD, 32'h11);
    m_tx_drop = 1;
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL drop_txdata got %h exp a5", tx_data); end
    e = con_exp(1'b1);
    bus_read(A_CON, d);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL drop_con got %h exp %h", d, e); end
    bus_write(A_CON, 32'h43);
    e = con_exp(1'b1);
    bus_read(A_CON, d);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL drop_w1c got %h exp %h", d, e); end
    tx_status = 1'b1;
    repeat (SYNC + 4) @(negedge sysclk);
    m_tx_done = 1;
  endtask

  task automatic test_rx_ovr();
    logic [31:0] d, e;
    rx_pulse(8'h01);
    rx_pulse(8'h02);
    e = con_exp(1'b0);
    bus_read(A_CON, d);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL ovr_con got %h exp %h", d, e); end
    // RXD read landing on the same edge as a new byte
    @(negedge sysclk);
    rx_data = 8'h03; rx_status = 1'b1;
    repeat (SYNC) @(negedge sysclk);
    bus.addr = A_RXD; bus.mem_read = 1'b1;
    #1 d = bus.rdata;
    @(negedge sysclk);
    bus.mem_read = 1'b0;
    n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL ovr_rxd got %h exp 02", d); end
    m_rx_buf = 8'h03; m_rx_valid = 1;
    repeat (2) @(negedge sysclk);
    rx_status = 1'b0;
    repeat (SYNC + 2) @(negedge sysclk);
    e = con_exp(1'b0);
    bus_read(A_CON, d);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL coincide_con got %h exp %h", d, e); end
    bus_read(A_RXD, d);
    n_checks++; if (d !== 32'h03) begin n_fail++; $display("FAIL coincide_rxd got %h exp 03", d); end
    bus_write(A_CON, 32'h23);
  endtask

  task automatic test_timeout();
    logic [31:0] d, e;
    logic [7:0] b;
    e = con_exp(1'b0);
    bus_read(A_CON, d);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL tmo_pre_con got %h exp %h", d, e); end
    b = 8'($urandom_range(0, 255));
    tx_status = 1'b1;
    bus_write(A_TXD, {24'b0, b});
    repeat (500) @(negedge sysclk);
    n_checks++; if (tx_ctrl !== 1'b1) begin n_fail++; $display("FAIL tmo_ctrl_hold got %b exp 1", tx_ctrl); end
    repeat (TMO) @(negedge sysclk);
    m_tx_drop = 1;
    n_checks++; if (tx_ctrl !== 1'b0) begin n_fail++; $display("FAIL tmo_ctrl_drop got %b exp 0", tx_ctrl); end
    e = con_exp(1'b0);
    bus_read(A_CON, d);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL tmo_con got %h exp %h", d, e); end
  endtask

  task automatic test_reset_busy();
    logic [31:0] d;
    bus_write(A_CON, 32'h3);
    bus_write(A_TXD, 32'h3C);
    repeat (3) @(negedge sysclk);
    tx_status = 1'b0;
    repeat (SYNC + 2) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    n_checks++; if (tx_ctrl !== 1'b0) begin n_fail++; $display("FAIL rst_busy_ctrl got %b exp 0", tx_ctrl); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_busy_irq got %b exp 0", irq); end
    bus.addr = A_CON; bus.mem_read = 1'b1;
    #1;
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_busy_con got %h exp 0", bus.rdata); end
    @(negedge sysclk);
    bus.mem_read = 1'b0;
    reset = 1'b0;
    model_clear();
    repeat (20) @(negedge sysclk);
    tx_status = 1'b1;
    repeat (SYNC + 4) @(negedge sysclk);
    bus_read(A_CON, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_busy_after got %h exp 0", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, e, a;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: rx_pulse(8'($urandom_range(0, 255)));
        1: begin
          e = {24'b0, m_rx_buf};
          bus_read(A_RXD, d);
          n_checks++; if (d !== e) begin n_fail++; $display("FAIL rnd_rxd it%0d got %h exp %h", i, d, e); end
        end
        2: begin
          e = con_exp(1'b0);
          bus_read(A_CON, d);
          n_checks++; if (d !== e) begin n_fail++; $display("FAIL rnd_con it%0d got %h exp %h", i, d, e); end
        end
        3: bus_write(A_CON, 32'($urandom_range(0, 127)));
        default: begin
          case ($urandom_range(0, 2))
            0: a = A_TXD;
            1: a = 32'h4000_0024;
            default: a = 32'h4000_0000 + 32'($urandom_range(0, 5) * 4);
          endcase
          bus_read(a, d);
          n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rnd_zero it%0d addr %h got %h exp 0", i, a, d); end
        end
      endcase
      @(negedge sysclk);
      n_checks++; if (irq !== irq_exp()) begin n_fail++; $display("FAIL rnd_irq it%0d got %b exp %b", i, irq, irq_exp()); end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_data = 8'h00; rx_status = 1'b0; tx_status = 1'b1;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.mem_write = 1'b0; bus.mem_read = 1'b0;
    model_clear();
    test_reset();
    test_rx_irq();
    test_tx();
    test_tx_drop();
    test_rx_ovr();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
